// File: rtl/div_tap_sel.sv
// rtl/div_tap_sel.sv - synchronizes divider taps and switches between them glitch-free.
// Optional tick counter enabled by DIV_TAP_SEL_CNT_EN.
module div_tap_sel #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       div_in,
  input  logic             sel_req,
  input  logic [1:0]       sel,
  output logic             sel_ack,
  output logic             busy,
  output logic [1:0]       cur_sel,
  output logic             div_out,
  output logic             tick,
  output logic [CNT_W-1:0] tick_cnt
);

  typedef enum logic {IDLE, SWITCH} state_t;

  state_t     state, state_nxt;
  logic [1:0] cur_sel_nxt;
  logic [1:0] pend, pend_nxt;
  logic       ack_nxt;
  logic       div_prev;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= div_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_sel <= 2'd0;
      pend    <= 2'd0;
      sel_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      cur_sel <= cur_sel_nxt;
      pend    <= pend_nxt;
      sel_ack <= ack_nxt;
    end
  end

  // A request is not sampled while sel_ack is high, so a held sel_req
  // yields one-cycle acks separated by at least one idle cycle.
  always_comb begin
    state_nxt   = state;
    cur_sel_nxt = cur_sel;
    pend_nxt    = pend;
    ack_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (sel_req && !sel_ack) begin
          if (sel != cur_sel) begin
            pend_nxt  = sel;
            state_nxt = SWITCH;
          end else begin
            ack_nxt = 1'b1;
          end
        end
      end
      SWITCH: begin
        if (!s[cur_sel] && !s[pend]) begin
          cur_sel_nxt = pend;
          ack_nxt     = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SWITCH);

  // Switching only when both taps are low keeps div_out low across the change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_out  <= 1'b0;
      div_prev <= 1'b0;
    end else begin
      div_out  <= s[cur_sel];
      div_prev <= div_out;
    end
  end

  assign tick = div_out & ~div_prev;

`ifdef DIV_TAP_SEL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else if (tick) tick_cnt <= tick_cnt + 1'b1;
  end
`else
  assign tick_cnt = '0;
`endif

endmodule

// File: tb/tb_div_tap_sel.sv
// tb/tb_div_tap_sel.sv - directed self-checking bench for div_tap_sel.
module tb_div_tap_sel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] div_in;
  logic       sel_req = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       sel_ack, busy, div_out, tick;
  logic [1:0] cur_sel;
  logic [3:0] tick_cnt;
  logic [3:0] tap_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  div_tap_sel #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .sel_req(sel_req), .sel(sel),
    .sel_ack(sel_ack), .busy(busy), .cur_sel(cur_sel), .div_out(div_out),
    .tick(tick), .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  // Clock divider model: tap k toggles at clk/2^(k+1).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tap_cnt <= 4'd0;
    else tap_cnt <= tap_cnt + 4'd1;
  end
  assign div_in = tap_cnt;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycles until tick seen at a negedge, or -1 when the budget runs out.
  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < max);
    if (!tick) n = -1;
  endtask

  task automatic wait_ack(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel_ack && n < max);
    if (!sel_ack) n = -1;
  endtask

  task automatic request(input logic [1:0] v);
    sel_req = 1'b1;
    sel     = v;
    @(negedge clk);
    sel_req = 1'b0;
  endtask

  int n, h, acks, exp_cnt;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_cur_sel", cur_sel, 0);
    check_eq("rst_div_out", div_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ack", sel_ack, 0);
    check_eq("rst_cnt", tick_cnt, 0);
    rst_n = 1'b1;

    // Default tap /2: first tick SYNC_STAGES+2 negedges after release
    wait_tick(20, n);
    check_eq("first_tick_lat", n, 4);
    wait_tick(20, n);
    check_eq("tick_space_2", n, 2);
    for (int i = 0; i < 8; i++) wait_tick(20, n);
    @(negedge clk);
`ifdef DIV_TAP_SEL_CNT_EN
    exp_cnt = 10;
`else
    exp_cnt = 0;
`endif
    check_eq("cnt_after_10", tick_cnt, exp_cnt);

    // Switch 0 -> 3
    sel_req = 1'b1;
    sel     = 2'd3;
    @(negedge clk);
    sel_req = 1'b0;
    check_eq("busy_next", busy, 1);
    if (sel_ack) n = 0; else wait_ack(17, n);
    check_eq("ack_in_time", int'(n >= 0), 1);
    check_eq("cur_sel_3", cur_sel, 3);
    check_eq("div_low_at_ack", div_out, 0);
    wait_tick(40, n);
    h = 0;
    while (div_out && h < 40) begin
      @(negedge clk);
      h++;
    end
    check_eq("high_run_16", h, 8);
    wait_tick(40, n);
    check_eq("tick_space_16", h + n, 16);

    // Switch 3 -> 2, then same-tap requests with sel_req held
    request(2'd2);
    wait_ack(20, n);
    check_eq("cur_sel_2", cur_sel, 2);
    @(negedge clk);
    sel_req = 1'b1;
    sel     = 2'd2;
    @(negedge clk);
    check_eq("same_ack", sel_ack, 1);
    check_eq("same_busy", busy, 0);
    @(negedge clk);
    check_eq("held_gap", sel_ack, 0);
    @(negedge clk);
    check_eq("held_reack", sel_ack, 1);
    sel_req = 1'b0;
    wait_tick(40, n);
    wait_tick(40, n);
    check_eq("tick_space_8", n, 8);

    // Back to 0, then 0 -> 3 with an ignored request while busy
    request(2'd0);
    wait_ack(20, n);
    check_eq("cur_sel_0", cur_sel, 0);
    @(negedge clk);
    acks = 0;
    request(2'd3);
    if (sel_ack) acks++;
    sel_req = 1'b1;
    sel     = 2'd1;
    @(negedge clk);
    sel_req = 1'b0;
    if (sel_ack) acks++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel_ack) acks++;
    end
    check_eq("ignored_acks", acks, 1);
    check_eq("ignored_cur", cur_sel, 3);

    // Reset in the middle of a 0 -> 2 switch
    request(2'd0);
    wait_ack(20, n);
    @(negedge clk);
    request(2'd2);
    check_eq("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_cur", cur_sel, 0);
    check_eq("mrst_div", div_out, 0);
    check_eq("mrst_cnt", tick_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(20, n);
    check_eq("mrst_first_tick", n, 4);
    wait_tick(20, n);
    check_eq("mrst_space_2", n, 2);

    // 17 ticks since reset wrap a 4-bit counter to 1
    for (int i = 0; i < 15; i++) wait_tick(20, n);
    @(negedge clk);
`ifdef DIV_TAP_SEL_CNT_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif
    check_eq("cnt_wrap", tick_cnt, exp_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
